serial_add_ctrl: RTL and testbench

Bit-serial adder sequencer. Time-shares one 1-bit full-adder cell across WIDTH cycles to add two WIDTH-bit operands, plus a carry-in, LSB first. A carry flip-flop chains the stages. Operands enter and results leave through valid/ready handshakes. Intended for area-constrained datapaths where a WIDTH-bit ripple adder is too costly.

---
 rtl/serial_add_pkg.sv | 29 ++
 rtl/serial_add_ctrl_fulladder.sv | 24 ++
 rtl/serial_add_ctrl.sv | 174 +++++++++++++++++
 tb/tb_serial_add_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_pkg
// Shared types and helpers for the bit-serial adder sequencer.
//   state_e       : controller FSM states (IDLE, RUN, DONE)
//   DEFAULT_WIDTH : default operand/result width
//   cnt_width()   : bit-counter width needed to count WIDTH processed bits
// Optional feature macro used by the top level: SERIAL_ADD_OVF_EN
// -----------------------------------------------------------------------------
package serial_add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int DEFAULT_WIDTH = 8;

   // Counter must hold 0..w-1. Never narrower than one bit.
   function automatic int cnt_width(input int w);
      int cw;
      cw = $clog2(w);
      if (cw < 1) begin
         cw = 1;
      end
      return cw;
   endfunction

endpackage : serial_add_pkg

// File: rtl/serial_add_ctrl_fulladder.sv
// -----------------------------------------------------------------------------
// fulladder
// 1-bit full-adder cell, purely combinational. Shared by the serial adder,
// which reuses it once per bit position.
// Ports:
//   a, b  : operand bits
//   cin   : carry in
//   sum   : a ^ b ^ cin
//   cout  : majority(a, b, cin)
// -----------------------------------------------------------------------------
module fulladder
   import serial_add_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : fulladder

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial adder sequencer. One 1-bit full adder is time-shared over WIDTH
// clock edges to compute {cout, sum} = a + b + cin, LSB first, with a carry
// flop chaining the bit positions.
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//   a, b, cin           : operands and carry-in
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   sum, cout           : registered result, held until the next run
//   ovf                 : signed overflow flag (only with SERIAL_ADD_OVF_EN)
//   busy                : high while bits are being processed (RUN)
// Optional feature: define SERIAL_ADD_OVF_EN to add the ovf output.
// -----------------------------------------------------------------------------
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
   output logic             ovf,
`endif
   output logic             busy
);

   localparam int CNT_W = cnt_width(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SERIAL_ADD_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic fa_sum;
   logic fa_cout;
   logic last_bit;

   // Shared datapath: always fed from the LSBs of the shift registers.
   fulladder u_fa (
      .a    (a_sh_q[0]),
      .b    (b_sh_q[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // The edge seen with cnt == WIDTH-1 processes the MSB.
   assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

   // ---------------------------------------------------------------- FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------- FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)  state_d = RUN;
         RUN:     if (last_bit)  state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------- FSM: outputs
   // Decoded from state only, so no combinational path from the handshake inputs.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state_q)
         IDLE:    in_ready  = 1'b1;
         RUN:     busy      = 1'b1;
         DONE:    out_valid = 1'b1;
         default: ;
      endcase
   end

   // ---------------------------------------------------------------- datapath next state
   always_comb begin
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_sh_d  = a;
               b_sh_d  = b;
               carry_d = cin;
               cnt_d   = '0;
            end
         end
         RUN: begin
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            // Result bits arrive LSB first, so they enter at the top and
            // reach their final position after WIDTH shifts.
            sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
            carry_d = fa_cout;
            cnt_d   = cnt_q + CNT_W'(1);
            if (last_bit) begin
               cout_d = fa_cout;
`ifdef SERIAL_ADD_OVF_EN
               // carry_q is the carry into the MSB; differing carries in and
               // out of the sign bit mean two's-complement overflow.
               ovf_d  = carry_q ^ fa_cout;
`endif
            end
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------- datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
// Self-checking bench for serial_add_ctrl (WIDTH=8). Expected results come
// from plain integer arithmetic on the operands: a + b + cin for the sum and
// carry, and a signed-range test for overflow when SERIAL_ADD_OVF_EN is set.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;
`ifdef SERIAL_ADD_OVF_EN
   logic             ovf;
`endif

   int total = 0;
   int bad   = 0;

   serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
`ifdef SERIAL_ADD_OVF_EN
      .ovf       (ovf),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete transaction. stall = DONE cycles held with out_ready=0,
   // meddle = keep driving in_valid with fresh operands during RUN.
   task automatic run_add(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                          input int stall, input bit meddle);
      logic [8:0] exp_full;
      int         n;
      int         sv;
      logic       exp_ovf;
      exp_full = 9'(ta) + 9'(tb) + 9'(tc);
      sv       = int'($signed(ta)) + int'($signed(tb)) + int'(tc);
      exp_ovf  = (sv > 127) || (sv < -128);

      check("in_ready_idle", 64'(in_ready), 64'd1);
      a = ta; b = tb; cin = tc; in_valid = 1'b1;
      out_ready = (stall == 0);
      @(posedge clk); #1;
      if (!meddle) in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < WIDTH + 20) begin
         check("busy_run", 64'(busy), 64'd1);
         check("in_ready_run", 64'(in_ready), 64'd0);
         if (meddle) begin
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
         end
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;
      check("latency", 64'(n), 64'(WIDTH));
      check("sum", 64'(sum), 64'(exp_full[7:0]));
      check("cout", 64'(cout), 64'(exp_full[8]));
`ifdef SERIAL_ADD_OVF_EN
      check("ovf", 64'(ovf), 64'(exp_ovf));
`endif
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         check("stall_out_valid", 64'(out_valid), 64'd1);
         check("stall_in_ready", 64'(in_ready), 64'd0);
         check("stall_sum", 64'(sum), 64'(exp_full[7:0]));
         check("stall_cout", 64'(cout), 64'(exp_full[8]));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("idle_out_valid", 64'(out_valid), 64'd0);
      check("idle_in_ready", 64'(in_ready), 64'd1);
      check("idle_sum_hold", 64'(sum), 64'(exp_full[7:0]));
      $display("add a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d latency=%0d stall=%0d meddle=%0d",
               ta, tb, tc, sum, cout, n, stall, meddle);
   endtask

   initial begin
      in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      // Reset values are visible before any clock edge.
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_sum", 64'(sum), 64'd0);
      check("rst_cout", 64'(cout), 64'd0);
`ifdef SERIAL_ADD_OVF_EN
      check("rst_ovf", 64'(ovf), 64'd0);
`endif
      #20 rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed cases.
      run_add(8'hFF, 8'h01, 1'b0, 0, 1'b0);
      check("ff01_sum", 64'(sum), 64'h00);
      check("ff01_cout", 64'(cout), 64'd1);
      run_add(8'h5A, 8'hA5, 1'b1, 0, 1'b0);
      check("5aa5_sum", 64'(sum), 64'h00);
      check("5aa5_cout", 64'(cout), 64'd1);
      run_add(8'h12, 8'h34, 1'b0, 0, 1'b0);
      check("1234_sum", 64'(sum), 64'h46);
      check("1234_cout", 64'(cout), 64'd0);
      run_add(8'hC3, 8'h3C, 1'b1, 5, 1'b0);    // backpressure
      run_add(8'h21, 8'h42, 1'b0, 0, 1'b1);    // in_valid noise during RUN
      check("noise_sum", 64'(sum), 64'h63);

      // Asynchronous reset in the middle of RUN.
      a = 8'h55; b = 8'h66; cin = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      check("midrun_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_in_ready", 64'(in_ready), 64'd1);
      check("arst_out_valid", 64'(out_valid), 64'd0);
      check("arst_sum", 64'(sum), 64'd0);
      check("arst_cout", 64'(cout), 64'd0);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_out_valid", 64'(out_valid), 64'd0);
      $display("async reset mid-run checked");
      run_add(8'h03, 8'h04, 1'b0, 0, 1'b0);
      check("0304_sum", 64'(sum), 64'h07);
      check("0304_cout", 64'(cout), 64'd0);

`ifdef SERIAL_ADD_OVF_EN
      run_add(8'h7F, 8'h01, 1'b0, 0, 1'b0);
      check("ovf_7f01", 64'(ovf), 64'd1);
      run_add(8'h80, 8'h80, 1'b0, 0, 1'b0);
      check("ovf_8080", 64'(ovf), 64'd1);
      check("ovf_8080_cout", 64'(cout), 64'd1);
      run_add(8'h10, 8'h20, 1'b0, 0, 1'b0);
      check("ovf_1020", 64'(ovf), 64'd0);
`endif

      // Random sweep.
      for (int k = 0; k < 1000; k++) begin
         run_add(8'($urandom), 8'($urandom), 1'($urandom),
                 int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule : tb_serial_add_ctrl
